// File: rtl/vmem_pkg.sv
// vmem_pkg: shared definitions for the frame-memory arbiter.
//   - default frame geometry and pixel width
//   - memory address width ({h, v} packed)
//   - clear-engine state encoding
package vmem_pkg;

    localparam int H_BITS_DEF   = 10;
    localparam int V_BITS_DEF   = 9;
    localparam int DATA_W_DEF   = 24;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int WQ_DEPTH_DEF = 4;

    // Memory address is {h, v}, so its width is the sum of both coordinates.
    localparam int ADDR_W_DEF = H_BITS_DEF + V_BITS_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/vmem_wr_fifo.sv
// vmem_wr_fifo: small synchronous FIFO holding pending pixel writes.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset (pointers only)
//   i_push, i_data  enqueue i_data (ignored when full)
//   i_pop           dequeue head (ignored when empty)
//   o_full, o_empty occupancy flags
//   o_head          entry at the head, valid when !o_empty
module vmem_wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4   // power of 2, >= 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it unreset lets it map onto RAM/LUTRAM.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: single-port frame-memory controller.
// Fixed priority per cycle: scan-out read, then clear engine, then write FIFO.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   rd_req, rd_h, rd_v          scan-out read request and coordinates
//   rd_data, rd_valid           read data, one cycle after rd_req
//   wr_valid/wr_ready, wr_h,
//   wr_v, wr_data               pixel-writer handshake into the write FIFO
//   clear_start, clear_color    start a full-frame fill with clear_color
//   busy                        clear engine running
//   wr_err                      sticky: an out-of-range pixel was dropped
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata        synchronous single-port memory interface
module vmem_arbiter
    import vmem_pkg::*;
#(
    parameter int H_BITS   = H_BITS_DEF,
    parameter int V_BITS   = V_BITS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int WQ_DEPTH = WQ_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     rd_req,
    input  logic [H_BITS-1:0]        rd_h,
    input  logic [V_BITS-1:0]        rd_v,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [H_BITS-1:0]        wr_h,
    input  logic [V_BITS-1:0]        wr_v,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     clear_start,
    input  logic [DATA_W-1:0]        clear_color,
    output logic                     busy,
    output logic                     wr_err,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [H_BITS+V_BITS-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int ADDR_W  = H_BITS + V_BITS;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    localparam logic [H_BITS-1:0] H_LAST = H_BITS'(H_ACTIVE - 1);
    localparam logic [V_BITS-1:0] V_LAST = V_BITS'(V_ACTIVE - 1);

    clr_state_e          r_state;
    clr_state_e          w_state_nxt;
    logic [H_BITS-1:0]   r_ch;
    logic [V_BITS-1:0]   r_cv;
    logic [DATA_W-1:0]   r_color;
    logic                r_rd_valid;
    logic                r_wr_err;

    logic                w_in_range;
    logic                w_wr_fire;
    logic                w_push;
    logic                w_pop;
    logic                w_grant_clr;
    logic                w_start_acc;
    logic                w_last_px;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [ENTRY_W-1:0]  w_head;

    // Range check on one extra bit so H_ACTIVE == 2**H_BITS cannot alias to 0.
    assign w_in_range = ({1'b0, wr_h} < (H_BITS+1)'(H_ACTIVE)) &&
                        ({1'b0, wr_v} < (V_BITS+1)'(V_ACTIVE));

    // Out-of-range pixels still complete the handshake but are never queued.
    assign wr_ready  = !w_fifo_full;
    assign w_wr_fire = wr_valid && wr_ready;
    assign w_push    = w_wr_fire && w_in_range;

    // FIFO drains only while the clear engine is idle, so queued pixels land
    // after the fill instead of being overwritten by it.
    assign w_grant_clr = !rd_req && (r_state == CLEAR);
    assign w_pop       = !rd_req && (r_state == IDLE) && !w_fifo_empty;
    assign w_start_acc = clear_start && (r_state == IDLE);
    assign w_last_px   = (r_ch == H_LAST) && (r_cv == V_LAST);

    vmem_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (WQ_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  ({wr_h, wr_v, wr_data}),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    // Memory slot: at most one access per cycle.
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rd_req) begin
            mem_en   = 1'b1;
            mem_addr = {rd_h, rd_v};
        end else if (w_grant_clr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {r_ch, r_cv};
            mem_wdata = r_color;
        end else if (w_pop) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = w_head[ENTRY_W-1:DATA_W];
            mem_wdata = w_head[DATA_W-1:0];
        end
    end

    // Clear FSM: state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Clear FSM: next state. clear_start is ignored while already clearing.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (clear_start)             w_state_nxt = CLEAR;
            CLEAR:   if (w_grant_clr && w_last_px) w_state_nxt = IDLE;
            default:                              w_state_nxt = IDLE;
        endcase
    end

    // Clear raster counters and latched fill colour.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ch    <= '0;
            r_cv    <= '0;
            r_color <= '0;
        end else if (w_start_acc) begin
            r_ch    <= '0;
            r_cv    <= '0;
            r_color <= clear_color;
        end else if (w_grant_clr) begin
            if (r_ch == H_LAST) begin
                r_ch <= '0;
                r_cv <= r_cv + 1'b1;
            end else begin
                r_ch <= r_ch + 1'b1;
            end
        end
    end

    // A drop in the same cycle as an accepted clear_start stays flagged: the
    // dropped pixel is newer information than the clear request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_rd_valid <= rd_req;
            if (w_wr_fire && !w_in_range) r_wr_err <= 1'b1;
            else if (w_start_acc)         r_wr_err <= 1'b0;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = mem_rdata;
    assign busy     = (r_state == CLEAR);
    assign wr_err   = r_wr_err;

endmodule

// File: doc/vmem_arbiter.md
# vmem_arbiter

Single-port frame-memory controller between the VGA scan-out path and one pixel-writer client (keyboard/text engine). Scan-out reads always win the memory cycle. Writes are buffered in a small FIFO and retire in cycles where no read is requested, mainly during blanking. A built-in clear engine fills the visible frame with one colour.

## Interface
- H_BITS, 10, horizontal address width
- V_BITS, 9, vertical address width
- DATA_W, 24, pixel width (RGB888)
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- WQ_DEPTH, 4, write FIFO depth (power of 2)

Ports:
- clk  in  1  system/pixel clock
- resetn  in  1  asynchronous, active-low reset
- rd_req  in  1  scan-out wants a pixel this cycle (tie to vga_ctrl valid)
- rd_h  in  H_BITS  read column
- rd_v  in  V_BITS  read row
- rd_data  out  DATA_W  pixel data, valid when rd_valid=1
- rd_valid  out  1  data for the rd_req issued one cycle earlier
- wr_valid  in  1  writer presents a pixel
- wr_ready  out  1  FIFO can accept a pixel
- wr_h  in  H_BITS  write column
- wr_v  in  V_BITS  write row
- wr_data  in  DATA_W  write pixel
- clear_start  in  1  one-cycle pulse that starts a frame clear
- clear_color  in  DATA_W  fill value, sampled on an accepted clear_start
- busy  out  1  clear engine running
- wr_err  out  1  sticky flag: an out-of-range write was dropped
- mem_en  out  1  memory access enable
- mem_we  out  1  write strobe
- mem_addr  out  H_BITS+V_BITS  address {h, v}
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  synchronous-read data, 1 cycle after mem_en & !mem_we

## Operation
- Slot arbitration each cycle uses fixed priority: rd_req, then the clear engine, then the FIFO head. Exactly one access is issued per cycle, or none.
- Read slot: mem_en=1, mem_we=0, mem_addr={rd_h,rd_v}. rd_valid is registered rd_req. rd_data = mem_rdata.
- Write handshake: a transfer occurs when wr_valid & wr_ready. wr_ready = !fifo_full. There is no pass-through when full.
- Range check happens at push. If wr_h>=H_ACTIVE or wr_v>=V_ACTIVE, the pixel is accepted (handshake completes), not stored, and wr_err is set.
- FIFO slot: pops the head, mem_we=1, addr/data from the head entry.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE→CLEAR on clear_start. This latches clear_color, zeroes ch/cv, and clears wr_err.
  - In CLEAR, each granted slot writes {ch,cv}. ch increments; at H_ACTIVE-1 it wraps to 0 and cv increments.
  - The write at (H_ACTIVE-1, V_ACTIVE-1) returns the FSM to IDLE.
  - clear_start while in CLEAR is ignored.
- FIFO writes stall while in CLEAR. FIFO pushes still proceed if there is space. Queued pixels land after the clear, so they are not overwritten.

## Timing
- Reset values: rd_valid=0, busy=0, wr_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_ready=1 (FIFO empty), FSM=IDLE.
- Read latency is 1 cycle (rd_req at cycle N → rd_valid/rd_data at N+1). It is never stalled.
- Memory outputs (mem_*) are combinational from the arbitration result and current state.
- FIFO: a push at cycle N is visible at the head at N+1. The earliest memory write is at N+1 if rd_req=0.
- Simultaneous push+pop when not full: occupancy is unchanged. The pop happens at the memory slot.
- busy rises the cycle after clear_start and falls the cycle after the last clear write. The minimum duration is H_ACTIVE*V_ACTIVE cycles with rd_req=0.
- Asserting resetn mid-clear or with a non-empty FIFO aborts everything. The FIFO is flushed and the FSM returns to IDLE. Memory contents are undefined.
- Clear counters and FIFO pointers wrap in their natural widths.

## Structure
- The package vmem_pkg holds H_ACTIVE/V_ACTIVE defaults, the address-width localparam (H_BITS+V_BITS), and the FSM state enum {IDLE, CLEAR}.
- One sub-module: vmem_wr_fifo, a synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop, full/empty, head data.
  - Async active-low reset on its pointers.
- The arbiter and clear FSM live in vmem_arbiter.

## Test plan
- Reset with resetn=0 for 3 cycles: all outputs take their reset values, and wr_ready=1.
- rd_req held 1 with rd_h=5, rd_v=7 while 3 writes are pushed: mem_we stays 0. rd_valid follows one cycle after rd_req. After the 4th push wr_ready=0. When rd_req drops, 4 writes issue on consecutive cycles, in order.
- Write (h=639,v=479,data=0xABCDEF) with rd_req=0: mem_we=1 and addr={639,479} the next cycle. A subsequent read of that address returns 0xABCDEF.
- Write h=640, v=0: the handshake completes, there is no mem_we, and wr_err=1. A following clear_start clears wr_err.
- clear_start with clear_color=0x000000 and rd_req toggling: every {h<640, v<480} address is written exactly once. busy stays 1 until the last write. A pixel pushed mid-clear lands after busy falls.
- resetn pulsed low mid-clear at cycle 1000: busy=0 immediately, and there are no further mem_we until new stimulus.
